fsm_estacionamiento_multi: RTL and testbench
============================================

Name: fsm_estacionamiento_multi

Overview:
Parametrised successor of the single-lane parking entry/exit detector. Handles N_LANES lanes, each with a two-beam sensor pair {a,b}. Each lane gets input synchronisation, debouncing and a direction-aware sequence FSM, and the block keeps a shared saturating occupancy counter with full/empty flags. It sits between the raw beam sensors and the parking display/barrier controller.

Parameters:
N_LANES, 2, number of lanes, each with its own {a,b} sensor pair (1..8).
DEB_CYCLES, 4, consecutive stable cycles required before a debounced sensor bit updates (>=1).
CAPACITY, 50, maximum occupancy (>=1).
CNT_W, $clog2(CAPACITY+1), occupancy counter width (derived, not overridden).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
sensor  in  2*N_LANES  raw beams; lane i = sensor[2i+1:2i] = {a,b}, 1 = beam blocked.
load  in  1  synchronous preload strobe for the occupancy counter.
load_val  in  CNT_W  preload value; values above CAPACITY are clamped to CAPACITY.
entrada  out  N_LANES  per-lane 1-cycle pulse: completed entry.
salida  out  N_LANES  per-lane 1-cycle pulse: completed exit.
count  out  CNT_W  current occupancy.
full  out  1  count == CAPACITY.
empty  out  1  count == 0.
overflow  out  1  1-cycle pulse: entries were discarded by saturation at CAPACITY.
underflow  out  1  1-cycle pulse: exits were discarded by saturation at 0.

Behaviour:
- Reset (sync, rst=1 at a clk edge): all FSMs go to IDLE; synchronisers, debounced values and stability counters clear to 0; count=0, empty=1, full=0; entrada, salida, overflow and underflow are 0. rst has priority over load and over all events.
- Sync: each raw bit passes through a 2-flop synchroniser.
- Debounce: per bit, if the synchronised value differs from the debounced value, a stability counter increments; otherwise the counter clears. When the counter reaches DEB_CYCLES, the debounced value takes the new value and the counter clears. A glitch shorter than DEB_CYCLES cycles never reaches the FSM. Latency from a raw edge to a debounced edge = 2+DEB_CYCLES cycles.
- Lane FSM states (on debounced {a,b}): IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A.
  - IDLE: 10->IN_A, 01->OUT_B; 11 and 00 stay in IDLE.
  - IN_A: 11->IN_AB; 00->IDLE (abort); 01->IDLE (invalid).
  - IN_AB: 01->IN_B; 10->IN_A (back-out); 00->IDLE.
  - IN_B: 00->IDLE with an entry event; 11->IN_AB (back-out); 10->IDLE (invalid).
  - OUT_B: 11->OUT_AB; 00->IDLE; 10->IDLE.
  - OUT_AB: 10->OUT_A; 01->OUT_B; 00->IDLE.
  - OUT_A: 00->IDLE with an exit event; 11->OUT_AB; 01->IDLE.
  - Unlisted inputs hold the current state. Illegal encodings go to IDLE.
- Pulses: entrada[i]/salida[i] are registered and high exactly the cycle after the FSM transition that produces the event. A lane cannot produce events on consecutive cycles.
- Occupancy: each cycle, E = popcount of entry events, X = popcount of exit events, across all lanes in the same cycle as those events.
  - next = count + E - X, computed signed with width CNT_W+2.
  - next > CAPACITY: count=CAPACITY, overflow pulse. next < 0: count=0, underflow pulse.
  - count updates in the same edge that raises entrada/salida.
  - Simultaneous entries and exits on different lanes net out with no error pulse, unless the net result saturates.
- load=1: count is set to min(load_val, CAPACITY). Events in that cycle are ignored for counting but still pulse entrada/salida. No overflow/underflow pulse in that cycle.
- full and empty are registered together with count and are never inconsistent with it.
- rst mid-sequence: the lane returns to IDLE with no pulse. A sequence already half-done is not resumed.

Test Plan:
- DEB_CYCLES=4, lane0 {a,b}: 00,10,11,01,00, each held 10 cycles -> entrada[0] single pulse; count 0->1; salida stays 0; pulse appears 6 cycles + 1 after the final raw 00.
- lane1: 00,01,11,10,00 starting from count=3 -> salida[1] single pulse; count=2; full=0, empty=0.
- lane0: 10,11,10,00 (back-out) -> no pulses, count unchanged. Also a 3-cycle glitch a=1 with DEB_CYCLES=4 -> FSM stays IDLE.
- CAPACITY=2, count=2, lane0 completes an entry in the same cycle lane1 completes an exit -> count stays 2, no overflow; then a lone entry -> count=2, overflow 1 cycle, full=1.
- count=0, exit completes -> count=0, underflow pulse. load=1, load_val=60, CAPACITY=50 -> count=50, full=1.
- rst asserted while lane0 is in IN_AB, then released with sensor=01 then 00 -> no entrada, count=0 (FSM went IDLE->OUT_B->IDLE).

Source files
------------

// File: rtl/fsm_estacionamiento_multi.sv
// Multi-lane parking entry/exit detector: per-lane sync + debounce + direction FSM,
// feeding a shared saturating occupancy counter with full/empty/overflow/underflow.
module fsm_estacionamiento_multi #(
  parameter int unsigned N_LANES    = 2,
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CAPACITY   = 50,
  localparam int unsigned CNT_W     = $clog2(CAPACITY + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*N_LANES-1:0] sensor,
  input  logic                 load,
  input  logic [CNT_W-1:0]     load_val,
  output logic [N_LANES-1:0]   entrada,
  output logic [N_LANES-1:0]   salida,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int unsigned NB    = 2 * N_LANES;
  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int unsigned EV_W  = $clog2(N_LANES + 1);
  // Wide enough for count + all lanes entering, plus sign and headroom.
  localparam int unsigned SUM_W = ((CNT_W > EV_W) ? CNT_W : EV_W) + 2;

  localparam logic [CNT_W-1:0]        CAP_C = CNT_W'(CAPACITY);
  localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);
  localparam logic [DEB_W-1:0]        DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IN_A   = 3'd1,
    IN_AB  = 3'd2,
    IN_B   = 3'd3,
    OUT_B  = 3'd4,
    OUT_AB = 3'd5,
    OUT_A  = 3'd6
  } lane_state_e;

  logic [NB-1:0]      sync1_q;
  logic [NB-1:0]      sync2_q;
  logic [NB-1:0]      deb_q;
  logic [DEB_W-1:0]   stab_q [NB];
  lane_state_e        state_q [N_LANES];
  logic [N_LANES-1:0] ent_ev_c;
  logic [N_LANES-1:0] ext_ev_c;

  logic [SUM_W-1:0]        n_ent_c;
  logic [SUM_W-1:0]        n_ext_c;
  logic signed [SUM_W-1:0] next_c;
  logic [CNT_W-1:0]        count_d;
  logic                    overflow_d;
  logic                    underflow_d;

  // Next lane state from the debounced {a,b} pair.
  function automatic lane_state_e lane_next(input lane_state_e s, input logic [1:0] ab);
    lane_state_e n;
    n = s;
    case (s)
      IDLE: begin
        case (ab)
          2'b10:   n = IN_A;
          2'b01:   n = OUT_B;
          default: n = IDLE;
        endcase
      end
      IN_A: begin
        case (ab)
          2'b11:   n = IN_AB;
          2'b00:   n = IDLE;
          2'b01:   n = IDLE;
          default: n = s;
        endcase
      end
      IN_AB: begin
        case (ab)
          2'b01:   n = IN_B;
          2'b10:   n = IN_A;
          2'b00:   n = IDLE;
          default: n = s;
        endcase
      end
      IN_B: begin
        case (ab)
          2'b00:   n = IDLE;
          2'b11:   n = IN_AB;
          2'b10:   n = IDLE;
          default: n = s;
        endcase
      end
      OUT_B: begin
        case (ab)
          2'b11:   n = OUT_AB;
          2'b00:   n = IDLE;
          2'b10:   n = IDLE;
          default: n = s;
        endcase
      end
      OUT_AB: begin
        case (ab)
          2'b10:   n = OUT_A;
          2'b01:   n = OUT_B;
          2'b00:   n = IDLE;
          default: n = s;
        endcase
      end
      OUT_A: begin
        case (ab)
          2'b00:   n = IDLE;
          2'b11:   n = OUT_AB;
          2'b01:   n = IDLE;
          default: n = s;
        endcase
      end
      default: n = IDLE;
    endcase
    return n;
  endfunction

  // Two-flop synchroniser on every raw beam bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sensor;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: accept a new value only after DEB_CYCLES stable cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= '0;
      for (int k = 0; k < NB; k++) stab_q[k] <= '0;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (sync2_q[k] != deb_q[k]) begin
          if (stab_q[k] == DEB_LAST) begin
            deb_q[k]  <= sync2_q[k];
            stab_q[k] <= '0;
          end else begin
            stab_q[k] <= stab_q[k] + DEB_W'(1);
          end
        end else begin
          stab_q[k] <= '0;
        end
      end
    end
  end

  // Completed-sequence events, visible in the same cycle as the FSM transition.
  always_comb begin
    ent_ev_c = '0;
    ext_ev_c = '0;
    for (int i = 0; i < N_LANES; i++) begin
      ent_ev_c[i] = (state_q[i] == IN_B)  && (deb_q[2*i +: 2] == 2'b00);
      ext_ev_c[i] = (state_q[i] == OUT_A) && (deb_q[2*i +: 2] == 2'b00);
    end
  end

  // Lane FSMs and their registered entry/exit pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_LANES; i++) state_q[i] <= IDLE;
      entrada <= '0;
      salida  <= '0;
    end else begin
      for (int i = 0; i < N_LANES; i++) state_q[i] <= lane_next(state_q[i], deb_q[2*i +: 2]);
      entrada <= ent_ev_c;
      salida  <= ext_ev_c;
    end
  end

  // Net occupancy update with saturation and preload.
  always_comb begin
    n_ent_c = '0;
    n_ext_c = '0;
    for (int i = 0; i < N_LANES; i++) begin
      n_ent_c = n_ent_c + SUM_W'(ent_ev_c[i]);
      n_ext_c = n_ext_c + SUM_W'(ext_ev_c[i]);
    end
    next_c      = $signed(SUM_W'(count)) + $signed(n_ent_c) - $signed(n_ext_c);
    count_d     = count;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (load) begin
      count_d = (load_val > CAP_C) ? CAP_C : load_val;
    end else if (next_c > CAP_S) begin
      count_d    = CAP_C;
      overflow_d = 1'b1;
    end else if (next_c[SUM_W-1]) begin
      count_d     = '0;
      underflow_d = 1'b1;
    end else begin
      count_d = CNT_W'(next_c);
    end
  end

  // Occupancy register; flags derive from the same next value so they never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_d;
      full      <= (count_d == CAP_C);
      empty     <= (count_d == '0);
      overflow  <= overflow_d;
      underflow <= underflow_d;
    end
  end

endmodule

// File: tb/tb_fsm_estacionamiento_multi.sv
// Scoreboard bench: stimulus pushes expected events, negedge monitors pop and compare.
module tb_fsm_estacionamiento_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests  = 0;
  int failed = 0;

  // DUT A: default parameters (CAPACITY=50, CNT_W=6)
  logic       rst_a, load_a, full_a, empty_a, ovf_a, unf_a;
  logic [3:0] sens_a;
  logic [5:0] load_val_a, count_a;
  logic [1:0] ent_a, sal_a;

  // DUT B: CAPACITY=2 (CNT_W=2)
  logic       rst_b, load_b, full_b, empty_b, ovf_b, unf_b;
  logic [3:0] sens_b;
  logic [1:0] load_val_b, count_b;
  logic [1:0] ent_b, sal_b;

  fsm_estacionamiento_multi #(.N_LANES(2), .DEB_CYCLES(4), .CAPACITY(50)) dut_a (
    .clk(clk), .rst(rst_a), .sensor(sens_a), .load(load_a), .load_val(load_val_a),
    .entrada(ent_a), .salida(sal_a), .count(count_a), .full(full_a), .empty(empty_a),
    .overflow(ovf_a), .underflow(unf_a)
  );

  fsm_estacionamiento_multi #(.N_LANES(2), .DEB_CYCLES(4), .CAPACITY(2)) dut_b (
    .clk(clk), .rst(rst_b), .sensor(sens_b), .load(load_b), .load_val(load_val_b),
    .entrada(ent_b), .salida(sal_b), .count(count_b), .full(full_b), .empty(empty_b),
    .overflow(ovf_b), .underflow(unf_b)
  );

  typedef struct {
    logic [1:0] ent;
    logic [1:0] sal;
    logic [5:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
    int         at;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [13:0] pk(input logic [1:0] ent, input logic [1:0] sal,
                                     input logic [5:0] cnt, input logic f, input logic e,
                                     input logic o, input logic u);
    return {ent, sal, cnt, f, e, o, u};
  endfunction

  task automatic push(input int d, input logic [1:0] ent, input logic [1:0] sal,
                      input logic [5:0] cnt, input logic f, input logic e,
                      input logic o, input logic u, input int at);
    exp_t x;
    x.ent = ent; x.sal = sal; x.cnt = cnt; x.full = f; x.empty = e;
    x.ovf = o; x.unf = u; x.at = at;
    if (d == 0) qa.push_back(x);
    else qb.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic [3:0] s, input int hold);
    if (d == 0) sens_a = s;
    else sens_b = s;
    repeat (hold) step();
  endtask

  task automatic do_load(input int d, input int v);
    if (d == 0) begin load_a = 1'b1; load_val_a = 6'(v); end
    else begin load_b = 1'b1; load_val_b = 2'(v); end
    step();
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  // Monitor for DUT A
  always @(negedge clk) begin
    exp_t e;
    if ((ent_a | sal_a) != 2'b00 || ovf_a || unf_a) begin
      if (qa.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL A_unexpected_event: got ent=%b sal=%b cnt=%0d ovf=%b unf=%b, required no event (cycle %0d)",
                 ent_a, sal_a, count_a, ovf_a, unf_a, cyc);
      end else begin
        e = qa.pop_front();
        chk("A_event", 32'(pk(ent_a, sal_a, count_a, full_a, empty_a, ovf_a, unf_a)),
            32'(pk(e.ent, e.sal, e.cnt, e.full, e.empty, e.ovf, e.unf)));
        if (e.at != 0) chk("A_latency", cyc, e.at);
      end
    end
  end

  // Monitor for DUT B
  always @(negedge clk) begin
    exp_t e;
    if ((ent_b | sal_b) != 2'b00 || ovf_b || unf_b) begin
      if (qb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL B_unexpected_event: got ent=%b sal=%b cnt=%0d ovf=%b unf=%b, required no event (cycle %0d)",
                 ent_b, sal_b, count_b, ovf_b, unf_b, cyc);
      end else begin
        e = qb.pop_front();
        chk("B_event", 32'(pk(ent_b, sal_b, 6'(count_b), full_b, empty_b, ovf_b, unf_b)),
            32'(pk(e.ent, e.sal, e.cnt, e.full, e.empty, e.ovf, e.unf)));
        if (e.at != 0) chk("B_latency", cyc, e.at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    sens_a = '0; sens_b = '0;
    load_a = 1'b0; load_b = 1'b0;
    load_val_a = '0; load_val_b = '0;
    repeat (3) step();
    rst_a = 1'b0; rst_b = 1'b0;

    // Reset state: {full,empty,ovf,unf,ent,sal}
    chk("A_reset_count", 32'(count_a), 0);
    chk("A_reset_flags", 32'({full_a, empty_a, ovf_a, unf_a, ent_a, sal_a}), 32'h40);
    chk("B_reset_count", 32'(count_b), 0);
    chk("B_reset_flags", 32'({full_b, empty_b, ovf_b, unf_b, ent_b, sal_b}), 32'h40);

    // Lane0 entry 00,10,11,01,00 -> pulse 7 cycles after the final raw 00, count 1
    drive(0, 4'b0000, 10);
    drive(0, 4'b0010, 10);
    drive(0, 4'b0011, 10);
    drive(0, 4'b0001, 10);
    push(0, 2'b01, 2'b00, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, cyc + 7);
    drive(0, 4'b0000, 10);

    // Preload 3, then lane1 exit 01,11,10,00 -> count 2
    do_load(0, 3);
    chk("A_load3_count", 32'(count_a), 3);
    drive(0, 4'b0100, 10);
    drive(0, 4'b1100, 10);
    drive(0, 4'b1000, 10);
    push(0, 2'b00, 2'b10, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0, cyc + 7);
    drive(0, 4'b0000, 10);

    // Lane0 back-out 10,11,10,00 -> nothing
    drive(0, 4'b0010, 10);
    drive(0, 4'b0011, 10);
    drive(0, 4'b0010, 10);
    drive(0, 4'b0000, 10);
    chk("A_backout_count", 32'(count_a), 2);

    // 3-cycle glitch on a; then 11,01,00 only completes an entry if the glitch leaked into IN_A
    drive(0, 4'b0010, 3);
    drive(0, 4'b0000, 10);
    drive(0, 4'b0011, 10);
    drive(0, 4'b0001, 10);
    drive(0, 4'b0000, 10);
    chk("A_glitch_count", 32'(count_a), 2);

    // Exit from empty -> underflow pulse, count stays 0
    do_load(0, 0);
    chk("A_load0_flags", 32'({count_a, full_a, empty_a}), 32'({6'd0, 1'b0, 1'b1}));
    drive(0, 4'b0100, 10);
    drive(0, 4'b1100, 10);
    drive(0, 4'b1000, 10);
    push(0, 2'b00, 2'b10, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, cyc + 7);
    drive(0, 4'b0000, 10);

    // Preload above capacity clamps to 50
    do_load(0, 60);
    chk("A_load_clamp", 32'({count_a, full_a, empty_a}), 32'({6'd50, 1'b1, 1'b0}));

    // Reset while lane0 sits in IN_AB; release with 01 then 00 -> no pulse
    drive(0, 4'b0010, 10);
    drive(0, 4'b0011, 10);
    sens_a = 4'b0001;
    rst_a = 1'b1;
    repeat (2) step();
    rst_a = 1'b0;
    drive(0, 4'b0001, 10);
    drive(0, 4'b0000, 10);
    chk("A_rst_mid_seq", 32'({count_a, full_a, empty_a}), 32'({6'd0, 1'b0, 1'b1}));

    // CAPACITY=2: full, simultaneous entry (lane0) and exit (lane1) net out
    do_load(1, 2);
    chk("B_load_full", 32'({count_b, full_b, empty_b}), 32'({2'd2, 1'b1, 1'b0}));
    drive(1, 4'b0110, 10);
    drive(1, 4'b1111, 10);
    drive(1, 4'b1001, 10);
    push(1, 2'b01, 2'b10, 6'd2, 1'b1, 1'b0, 1'b0, 1'b0, cyc + 7);
    drive(1, 4'b0000, 10);

    // Lone entry at capacity -> overflow pulse, count held at 2
    drive(1, 4'b0010, 10);
    drive(1, 4'b0011, 10);
    drive(1, 4'b0001, 10);
    push(1, 2'b01, 2'b00, 6'd2, 1'b1, 1'b0, 1'b1, 1'b0, cyc + 7);
    drive(1, 4'b0000, 10);
    chk("B_after_ovf", 32'({count_b, full_b, ovf_b}), 32'({2'd2, 1'b1, 1'b0}));

    repeat (5) step();
    chk("A_queue_drained", 32'(qa.size()), 0);
    chk("B_queue_drained", 32'(qb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
